// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file slice.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NRD    = 2;
  localparam int RF_NWR    = 2;

  typedef logic [RF_ADDR_W-1:0] rf_idx_t;

  localparam rf_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: bset marks a producer in flight, an accepted
// write retires it; a same-cycle set beats the clear. Register 0 never goes busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NWR    = RF_NWR,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic                  bset,
  input  logic [ADDR_W-1:0]     bset_addr,
  output logic [NREGS-1:0]      busy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NREGS-1:0]  busy_r;
  logic [NREGS-1:0]  set_s;
  logic [NREGS-1:0]  clr_s;
  logic [NREGS-1:0]  busy_nxt_s;
  logic [ADDR_W-1:0] wa_s [NWR];

  for (genvar p = 0; p < NWR; p++) begin : g_wa
    assign wa_s[p] = waddr[p*ADDR_W +: ADDR_W];
  end

  // Next busy vector: a new producer supersedes a retiring one
  always_comb begin
    set_s = {NREGS{1'b0}};
    clr_s = {NREGS{1'b0}};
    for (int p = 0; p < NWR; p++) begin
      clr_s[wa_s[p]] = clr_s[wa_s[p]] | (we[p] & (wa_s[p] != ZERO_IDX));
    end
    set_s[bset_addr] = bset & (bset_addr != ZERO_IDX);
    busy_nxt_s       = set_s | (busy_r & ~clr_s);
    busy_nxt_s[0]    = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async read ports, NWR write ports (highest port
// wins on conflict), busy scoreboard. Define RF_BYPASS_EN for write-to-read bypass.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = RF_NRD,
  parameter int NWR    = RF_NWR,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  bset,
  input  logic [ADDR_W-1:0]     bset_addr,
  output logic [NREGS-1:0]      busy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_r [NREGS];
  logic [ADDR_W-1:0] wa_s  [NWR];
  logic [DATA_W-1:0] wd_s  [NWR];
  logic [NREGS-1:0]  busy_s;

  logic [NRD*DATA_W-1:0] rdata_s;
  logic [NRD-1:0]        rbusy_s;
  logic [ADDR_W-1:0]     ra_s;
  logic [DATA_W-1:0]     rd_s;
  logic                  rb_s;

  for (genvar p = 0; p < NWR; p++) begin : g_wport
    assign wa_s[p] = waddr[p*ADDR_W +: ADDR_W];
    assign wd_s[p] = wdata[p*DATA_W +: DATA_W];
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NWR    (NWR),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .bset      (bset),
    .bset_addr (bset_addr),
    .busy      (busy_s)
  );

  // Data array; ports are applied in ascending order so the highest port wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (wa_s[p] != ZERO_IDX)) begin
          mem_r[wa_s[p]] <= wd_s[p];
        end
      end
    end
  end

  // Read muxing with optional same-cycle bypass; everything reads 0 under reset
  always_comb begin
    rdata_s = {(NRD*DATA_W){1'b0}};
    rbusy_s = {NRD{1'b0}};
    ra_s    = {ADDR_W{1'b0}};
    rd_s    = {DATA_W{1'b0}};
    rb_s    = 1'b0;
    for (int r = 0; r < NRD; r++) begin
      ra_s = raddr[r*ADDR_W +: ADDR_W];
      if (ra_s == ZERO_IDX) begin
        rd_s = {DATA_W{1'b0}};
      end else begin
        rd_s = mem_r[ra_s];
      end
      rb_s = busy_s[ra_s];
`ifdef RF_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (wa_s[p] == ra_s) && (ra_s != ZERO_IDX)) begin
          rd_s = wd_s[p];
          rb_s = rb_s & bset & (bset_addr == ra_s);
        end else begin
          rd_s = rd_s;
          rb_s = rb_s;
        end
      end
`else
      rd_s = rd_s;
`endif
      if (rst) begin
        rdata_s[r*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rbusy_s[r]                  = 1'b0;
      end else begin
        rdata_s[r*DATA_W +: DATA_W] = rd_s;
        rbusy_s[r]                  = rb_s;
      end
    end
  end

  assign rdata = rdata_s;
  assign rbusy = rbusy_s;
  assign busy  = busy_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver pushes predicted outputs, monitor
// compares them on the falling edge.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int NREGS = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*DW-1:0]   wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*DW-1:0]   rdata;
  logic [NRD-1:0]      rbusy;
  logic                bset;
  logic [AW-1:0]       bset_addr;
  logic [NREGS-1:0]    busy;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .bset(bset), .bset_addr(bset_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rb;
    logic [NREGS-1:0]  bz;
  } exp_t;

  exp_t     q[$];
  bit [31:0] m_mem  [NREGS];
  bit        m_busy [NREGS];
  int        tests = 0;
  int        fails = 0;

  // Reference prediction of outputs from the model and current inputs
  function automatic exp_t predict();
    exp_t e;
    e = '0;
    for (int i = 0; i < NREGS; i++) e.bz[i] = m_busy[i];
    for (int r = 0; r < NRD; r++) begin
      int ra;
      bit [31:0] d;
      bit b;
      ra = int'(raddr[r*AW +: AW]);
      d  = (ra == 0) ? 32'd0 : m_mem[ra];
      b  = m_busy[ra];
`ifdef RF_BYPASS_EN
      if (ra != 0) begin
        int hit;
        hit = -1;
        for (int p = 0; p < NWR; p++)
          if (we[p] && int'(waddr[p*AW +: AW]) == ra) hit = p;
        if (hit >= 0) begin
          d = wdata[hit*DW +: DW];
          if (!(bset && int'(bset_addr) == ra)) b = 1'b0;
        end
      end
`endif
      if (rst) begin
        d = 32'd0;
        b = 1'b0;
      end
      e.rd[r*DW +: DW] = d;
      e.rb[r]          = b;
    end
    return e;
  endfunction

  // Apply the edge that just happened to the model
  task automatic commit();
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) begin
        int winner;
        bit setme;
        winner = -1;
        for (int p = 0; p < NWR; p++)
          if (we[p] && int'(waddr[p*AW +: AW]) == i) winner = p;
        if (winner >= 0) m_mem[i] = wdata[winner*DW +: DW];
        setme = bset && int'(bset_addr) == i;
        if (setme) m_busy[i] = 1'b1;
        else if (winner >= 0) m_busy[i] = 1'b0;
      end
    end
  endtask

  task automatic apply(input logic r_i, input logic [1:0] we_i,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [19:0] ra_i,
                       input logic b_i, input logic [4:0] ba_i);
    rst       = r_i;
    we        = we_i;
    waddr     = {a1, a0};
    wdata     = {d1, d0};
    raddr     = ra_i;
    bset      = b_i;
    bset_addr = ba_i;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_mem[i]  = 32'd0;
        m_busy[i] = 1'b0;
      end
    end
    q.push_back(predict());
    @(posedge clk);
    #1;
    commit();
  endtask

  function automatic logic [19:0] rd4(input logic [4:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Monitor: outputs are valid every cycle, compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (rdata !== e.rd) begin
          fails++;
          $display("FAIL rdata t=%0t got=%h exp=%h raddr=%h", $time, rdata, e.rd, raddr);
        end
        tests++;
        if (rbusy !== e.rb) begin
          fails++;
          $display("FAIL rbusy t=%0t got=%b exp=%b raddr=%h", $time, rbusy, e.rb, raddr);
        end
        tests++;
        if (busy !== e.bz) begin
          fails++;
          $display("FAIL busy t=%0t got=%h exp=%h", $time, busy, e.bz);
        end
      end
    end
  end

  initial begin
    logic [4:0] a0, a1, b_a;
    logic [19:0] ra;
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
    bset = 1'b0; bset_addr = '0;
    @(posedge clk);
    #1;
    apply(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd0, 5'd1, 5'd2, 5'd3), 1'b0, 5'd0);
    apply(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd4, 5'd5, 5'd6, 5'd7), 1'b0, 5'd0);
    // fill r1..r31 and mark a few busy
    for (int i = 1; i < NREGS; i += 2) begin
      a0 = 5'(i);
      a1 = 5'(i + 1);
      apply(1'b0, (i + 1 < NREGS) ? 2'b11 : 2'b01, a0, $urandom, a1, $urandom,
            rd4(5'(i - 1), a0, 5'($urandom_range(0, 31)), 5'd0), 1'b1, 5'(i + 3));
    end
    // reset mid-run with writes and sets pending
    apply(1'b1, 2'b11, 5'd3, 32'hAAAA5555, 5'd4, 32'h5555AAAA, rd4(5'd3, 5'd4, 5'd5, 5'd6), 1'b1, 5'd6);
    apply(1'b1, 2'b11, 5'd8, 32'h11111111, 5'd9, 32'h22222222, rd4(5'd8, 5'd9, 5'd31, 5'd1), 1'b1, 5'd8);
    apply(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd1, 5'd3, 5'd8, 5'd31), 1'b0, 5'd0);
    // basic write/read
    apply(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, rd4(5'd5, 5'd5, 5'd0, 5'd1), 1'b0, 5'd0);
    apply(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd5, 5'd0, 5'd5, 5'd1), 1'b0, 5'd0);
    // r0 rules
    apply(1'b0, 2'b11, 5'd0, 32'h12345678, 5'd0, 32'h9ABCDEF0, rd4(5'd0, 5'd0, 5'd0, 5'd0), 1'b1, 5'd0);
    apply(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd0, 5'd0, 5'd0, 5'd5), 1'b0, 5'd0);
    // write conflict
    apply(1'b0, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, rd4(5'd7, 5'd7, 5'd0, 5'd5), 1'b0, 5'd0);
    apply(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd7, 5'd5, 5'd7, 5'd0), 1'b0, 5'd0);
    // scoreboard set / clear / set-beats-clear
    apply(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd9, 5'd9, 5'd0, 5'd0), 1'b1, 5'd9);
    apply(1'b0, 2'b01, 5'd9, 32'hCAFE0009, 5'd0, 32'd0, rd4(5'd9, 5'd9, 5'd0, 5'd0), 1'b0, 5'd0);
    apply(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd9, 5'd0, 5'd9, 5'd0), 1'b0, 5'd0);
    apply(1'b0, 2'b10, 5'd0, 32'd0, 5'd9, 32'hBEEF0009, rd4(5'd9, 5'd9, 5'd0, 5'd0), 1'b1, 5'd9);
    apply(1'b0, 2'b01, 5'd3, 32'h33333333, 5'd0, 32'd0, rd4(5'd9, 5'd3, 5'd0, 5'd9), 1'b0, 5'd0);
    // multi-port reads: r3, r3, r0, busy r9
    apply(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rd4(5'd3, 5'd3, 5'd0, 5'd9), 1'b0, 5'd0);
    // randomized traffic, biased toward a few registers to force collisions
    for (int n = 0; n < 600; n++) begin
      a0  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a1  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      b_a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ra  = rd4(($urandom_range(0, 1) == 0) ? a0 : 5'($urandom),
                ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 3)),
                5'($urandom), b_a);
      apply(($urandom_range(0, 79) == 0), 2'($urandom), a0, $urandom, a1, $urandom,
            ra, ($urandom_range(0, 2) == 0), b_a);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
